mdu_ctrl: RTL

Multi-cycle multiply/divide sequencer sitting in the E stage beside the ALU. It accepts one MDU operation per request, holds the HI/LO architectural registers, and models fixed mult/div latency with a busy counter. It also produces the D-stage stall request for MDU hazards. An exception request (req) gates the start of new operations.

---
 rtl/mdu_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide sequencer: owns HI/LO, models fixed MDU latency, raises D-stage stalls.
// Optional MADD/MADDU/MSUB/MSUBU support is enabled by defining MDU_MADD_EN.
module mdu_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        req,
  input  logic        d_is_mdu,
  output logic        busy,
  output logic        d_stall,
  output logic [31:0] rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  lat;
  logic [31:0]       p_hi, p_lo;
  logic              long_op;
  logic              accept;
  logic [63:0]       res;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        rs_mag, rt_mag, q_u, r_u, q_mag, r_mag, q_s, r_s;
  logic               div_zero;

  assign accept = start & ~req & ~busy;

  assign prod_s = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
  assign prod_u = {32'b0, rs_data} * {32'b0, rt_data};

  // Signed divide works on magnitudes so INT_MIN / -1 wraps to INT_MIN with no overflow trap.
  assign rs_mag   = rs_data[31] ? -rs_data : rs_data;
  assign rt_mag   = rt_data[31] ? -rt_data : rt_data;
  assign div_zero = (rt_data == 32'd0);

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    q_u   = '0;
    r_u   = '0;
    q_mag = '0;
    r_mag = '0;
    if (!div_zero) begin
      q_u   = rs_data / rt_data;
      r_u   = rs_data % rt_data;
      q_mag = rs_mag / rt_mag;
      r_mag = rs_mag % rt_mag;
    end
  end

  assign q_s = (rs_data[31] ^ rt_data[31]) ? -q_mag : q_mag;
  assign r_s = rs_data[31] ? -r_mag : r_mag;

  // Latency class and result of the op presented this cycle.
  always_comb begin
    long_op = 1'b0;
    lat     = '0;
    res     = {hi, lo};
    case (op)
      OP_MULT:  begin long_op = 1'b1; lat = CNT_W'(MULT_LAT); res = prod_s; end
      OP_MULTU: begin long_op = 1'b1; lat = CNT_W'(MULT_LAT); res = prod_u; end
      OP_DIV: begin
        long_op = 1'b1;
        lat     = CNT_W'(DIV_LAT);
        if (!div_zero) res = {r_s, q_s};
      end
      OP_DIVU: begin
        long_op = 1'b1;
        lat     = CNT_W'(DIV_LAT);
        if (!div_zero) res = {r_u, q_u};
      end
`ifdef MDU_MADD_EN
      OP_MADD:  begin long_op = 1'b1; lat = CNT_W'(MULT_LAT); res = {hi, lo} + prod_s; end
      OP_MADDU: begin long_op = 1'b1; lat = CNT_W'(MULT_LAT); res = {hi, lo} + prod_u; end
      OP_MSUB:  begin long_op = 1'b1; lat = CNT_W'(MULT_LAT); res = {hi, lo} - prod_s; end
      OP_MSUBU: begin long_op = 1'b1; lat = CNT_W'(MULT_LAT); res = {hi, lo} - prod_u; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking for all state so every register samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept && long_op) state_next = RUN;
      RUN:  if (cnt == CNT_W'(1))  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state == RUN);
    d_stall = d_is_mdu & (busy | (start & ~req & long_op));
    case (op)
      OP_MFHI: rd_data = hi;
      OP_MFLO: rd_data = lo;
      default: rd_data = '0;
    endcase
  end

  // Datapath: pending result captured at accept, committed on the 1->0 counter edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      hi   <= '0;
      lo   <= '0;
      p_hi <= '0;
      p_lo <= '0;
    end else if (state == IDLE) begin
      if (accept) begin
        if (long_op) begin
          {p_hi, p_lo} <= res;
          cnt          <= lat;
        end else if (op == OP_MTHI) begin
          hi <= rs_data;
        end else if (op == OP_MTLO) begin
          lo <= rs_data;
        end
      end
    end else begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) {hi, lo} <= {p_hi, p_lo};
    end
  end

endmodule
